// File: rtl/penalty_round_ctl.sv
// Penalty-round sequencer: waits for a shot, times the ball flight, judges goal
// or save against the gloves position, holds the result and keeps the match tally.
module penalty_round_ctl #(
    parameter int unsigned FLIGHT_TICKS = 32_500_000,
    parameter int unsigned SHOW_TICKS   = 65_000_000,
    parameter int unsigned AIM_TIMEOUT  = 325_000_000,
    parameter int unsigned HIT_X        = 64,
    parameter int unsigned HIT_Y        = 48,
    parameter int unsigned MAX_ROUNDS   = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        round_start_i,
    input  logic        match_clear_i,
    input  logic        shot_valid_i,
    input  logic [11:0] shot_xpos_i,
    input  logic [11:0] shot_ypos_i,
    input  logic [11:0] gloves_xpos_i,
    input  logic [11:0] gloves_ypos_i,
    output logic        ball_launch_o,
    output logic [11:0] ball_xpos_o,
    output logic [11:0] ball_ypos_o,
    output logic        in_flight_o,
    output logic        is_scored_o,
    output logic        round_done_o,
    output logic [3:0]  goals_o,
    output logic [3:0]  saves_o,
    output logic [3:0]  rounds_o,
    output logic        match_over_o,
    output logic        busy_o,
    output logic [2:0]  dbg_state_o
);

    // Handshake: round_start_i, match_clear_i and shot_valid_i are single-cycle
    // pulses sampled on the rising edge; there is no back-pressure on any input.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AIM    = 3'd1,
        S_FLIGHT = 3'd2,
        S_JUDGE  = 3'd3,
        S_SHOW   = 3'd4
    } state_e;

    localparam logic [31:0] FLIGHT_LAST = 32'(FLIGHT_TICKS - 1);
    localparam logic [31:0] SHOW_LAST   = 32'(SHOW_TICKS - 1);
    localparam logic [31:0] AIM_LAST    = 32'(AIM_TIMEOUT - 1);
    localparam logic [3:0]  ROUNDS_MAX  = 4'(MAX_ROUNDS);
    localparam logic [12:0] HIT_X_LIM   = 13'(HIT_X);
    localparam logic [12:0] HIT_Y_LIM   = 13'(HIT_Y);

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic        forced_q, forced_d;
    logic [11:0] ball_x_q, ball_x_d;
    logic [11:0] ball_y_q, ball_y_d;
    logic        launch_q, launch_d;
    logic        in_flight_q, in_flight_d;
    logic        is_scored_q, is_scored_d;
    logic        done_q, done_d;
    logic [3:0]  goals_q, goals_d;
    logic [3:0]  saves_q, saves_d;
    logic [3:0]  rounds_q, rounds_d;
    logic        match_over_q, match_over_d;
    logic        busy_q, busy_d;

    // Distances are taken on 13-bit signed differences so gloves left of or
    // above the ball still produce a positive magnitude.
    logic signed [12:0] diff_x, diff_y;
    logic [12:0]        abs_x, abs_y;
    logic               in_window;

    always_comb begin
        diff_x    = $signed({1'b0, ball_x_q}) - $signed({1'b0, gloves_xpos_i});
        diff_y    = $signed({1'b0, ball_y_q}) - $signed({1'b0, gloves_ypos_i});
        abs_x     = diff_x[12] ? 13'(-diff_x) : 13'(diff_x);
        abs_y     = diff_y[12] ? 13'(-diff_y) : 13'(diff_y);
        in_window = (abs_x <= HIT_X_LIM) && (abs_y <= HIT_Y_LIM);
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        forced_d     = forced_q;
        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        launch_d     = 1'b0;
        in_flight_d  = 1'b0;
        is_scored_d  = is_scored_q;
        done_d       = 1'b0;
        goals_d      = goals_q;
        saves_d      = saves_q;
        rounds_d     = rounds_q;
        match_over_d = (rounds_q == ROUNDS_MAX);

        case (state_q)
            S_IDLE: begin
                if (round_start_i && !match_over_q) begin
                    state_d = S_AIM;
                    timer_d = 32'd0;
                end
            end
            S_AIM: begin
                // A shot in the timeout cycle still counts as a shot.
                if (shot_valid_i) begin
                    ball_x_d    = shot_xpos_i;
                    ball_y_d    = shot_ypos_i;
                    launch_d    = 1'b1;
                    in_flight_d = 1'b1;
                    forced_d    = 1'b0;
                    state_d     = S_FLIGHT;
                    timer_d     = 32'd0;
                end else if (timer_q == AIM_LAST) begin
                    forced_d = 1'b1;
                    state_d  = S_JUDGE;
                    timer_d  = 32'd0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_FLIGHT: begin
                if (timer_q == FLIGHT_LAST) begin
                    state_d = S_JUDGE;
                    timer_d = 32'd0;
                end else begin
                    in_flight_d = 1'b1;
                    timer_d     = timer_q + 32'd1;
                end
            end
            S_JUDGE: begin
                if (forced_q || in_window) begin
                    is_scored_d = 1'b0;
                    saves_d     = (saves_q == 4'hF) ? saves_q : saves_q + 4'd1;
                end else begin
                    is_scored_d = 1'b1;
                    goals_d     = (goals_q == 4'hF) ? goals_q : goals_q + 4'd1;
                end
                state_d = S_SHOW;
                timer_d = 32'd0;
            end
            S_SHOW: begin
                if (timer_q == SHOW_LAST) begin
                    rounds_d = (rounds_q == 4'hF) ? rounds_q : rounds_q + 4'd1;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                    timer_d  = 32'd0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = 32'd0;
            end
        endcase

        // Clearing the match aborts the round and cancels anything it would
        // have produced in this cycle; the last ball position is kept.
        if (match_clear_i) begin
            state_d      = S_IDLE;
            timer_d      = 32'd0;
            forced_d     = 1'b0;
            ball_x_d     = ball_x_q;
            ball_y_d     = ball_y_q;
            launch_d     = 1'b0;
            in_flight_d  = 1'b0;
            is_scored_d  = 1'b0;
            done_d       = 1'b0;
            goals_d      = 4'd0;
            saves_d      = 4'd0;
            rounds_d     = 4'd0;
            match_over_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            timer_q      <= 32'd0;
            forced_q     <= 1'b0;
            ball_x_q     <= 12'd0;
            ball_y_q     <= 12'd0;
            launch_q     <= 1'b0;
            in_flight_q  <= 1'b0;
            is_scored_q  <= 1'b0;
            done_q       <= 1'b0;
            goals_q      <= 4'd0;
            saves_q      <= 4'd0;
            rounds_q     <= 4'd0;
            match_over_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            forced_q     <= forced_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            launch_q     <= launch_d;
            in_flight_q  <= in_flight_d;
            is_scored_q  <= is_scored_d;
            done_q       <= done_d;
            goals_q      <= goals_d;
            saves_q      <= saves_d;
            rounds_q     <= rounds_d;
            match_over_q <= match_over_d;
            busy_q       <= busy_d;
        end
    end

    assign ball_launch_o = launch_q;
    assign ball_xpos_o   = ball_x_q;
    assign ball_ypos_o   = ball_y_q;
    assign in_flight_o   = in_flight_q;
    assign is_scored_o   = is_scored_q;
    assign round_done_o  = done_q;
    assign goals_o       = goals_q;
    assign saves_o       = saves_q;
    assign rounds_o      = rounds_q;
    assign match_over_o  = match_over_q;
    assign busy_o        = busy_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_penalty_round_ctl.sv
// Bench for penalty_round_ctl: per-round timing and tally against a round-level
// model, plus match completion, clear/reset aborts and collision corner cases.
module tb_penalty_round_ctl;

    localparam int FT = 4;
    localparam int ST = 3;
    localparam int AT = 20;
    localparam int HX = 64;
    localparam int HY = 48;
    localparam int MR = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        round_start = 1'b0;
    logic        match_clear = 1'b0;
    logic        shot_valid = 1'b0;
    logic [11:0] shot_xpos = '0;
    logic [11:0] shot_ypos = '0;
    logic [11:0] gloves_xpos = '0;
    logic [11:0] gloves_ypos = '0;
    logic        ball_launch;
    logic [11:0] ball_xpos;
    logic [11:0] ball_ypos;
    logic        in_flight;
    logic        is_scored;
    logic        round_done;
    logic [3:0]  goals;
    logic [3:0]  saves;
    logic [3:0]  rounds;
    logic        match_over;
    logic        busy;
    logic [2:0]  dbg_state;

    int vec_count = 0;
    int miscompares = 0;

    // Expected round results, packed {is_scored, goals, saves, rounds}.
    logic [12:0] exp_q[$];
    int          m_goals, m_saves, m_rounds;
    logic [11:0] m_bx, m_by;

    penalty_round_ctl #(
        .FLIGHT_TICKS(FT), .SHOW_TICKS(ST), .AIM_TIMEOUT(AT),
        .HIT_X(HX), .HIT_Y(HY), .MAX_ROUNDS(MR)
    ) dut (
        .clk_i(clk), .rst_i(rst), .round_start_i(round_start),
        .match_clear_i(match_clear), .shot_valid_i(shot_valid),
        .shot_xpos_i(shot_xpos), .shot_ypos_i(shot_ypos),
        .gloves_xpos_i(gloves_xpos), .gloves_ypos_i(gloves_ypos),
        .ball_launch_o(ball_launch), .ball_xpos_o(ball_xpos), .ball_ypos_o(ball_ypos),
        .in_flight_o(in_flight), .is_scored_o(is_scored), .round_done_o(round_done),
        .goals_o(goals), .saves_o(saves), .rounds_o(rounds),
        .match_over_o(match_over), .busy_o(busy), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_goals = 0;
        m_saves = 0;
        m_rounds = 0;
        exp_q.delete();
    endtask

    function automatic bit judge_goal(input int sx, input int sy, input int gx, input int gy);
        int dx, dy;
        dx = sx - gx;
        dy = sy - gy;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        return !((dx <= HX) && (dy <= HY));
    endfunction

    task automatic pulse_clear();
        match_clear = 1'b1;
        tick();
        match_clear = 1'b0;
        model_clear();
    endtask

    // One full round: start, optional shot after d AIM cycles, optional
    // stray round_start/shot_valid during flight, then check timing and tally.
    task automatic run_round(input bit shoot, input int d, input int sx, input int sy,
                             input int gx, input int gy, input bit noisy);
        int rel, launch_cnt, launch_rel, flight_cnt, flight_first, busy_cnt, done_rel;
        int exp_done, exp_launch_rel;
        bit goal, clash;
        logic [12:0] exp_res;
        gloves_xpos = 12'(gx);
        gloves_ypos = 12'(gy);
        goal = shoot ? judge_goal(sx, sy, gx, gy) : 1'b0;
        if (goal) m_goals = (m_goals < 15) ? m_goals + 1 : 15;
        else      m_saves = (m_saves < 15) ? m_saves + 1 : 15;
        m_rounds = m_rounds + 1;
        exp_q.push_back({goal, 4'(m_goals), 4'(m_saves), 4'(m_rounds)});
        if (shoot) begin
            m_bx = 12'(sx);
            m_by = 12'(sy);
        end
        exp_done       = shoot ? (d + 1 + FT + 1 + ST) : (AT + 1 + ST);
        exp_launch_rel = shoot ? d + 1 : -1;

        round_start = 1'b1;
        tick();
        round_start = 1'b0;
        rel = 0;
        launch_cnt = 0; launch_rel = -1; flight_cnt = 0; flight_first = -1;
        done_rel = -1; clash = 1'b0;
        busy_cnt = busy ? 1 : 0;
        while (done_rel < 0 && rel < 200) begin
            if (shoot && rel == d) begin
                shot_valid = 1'b1;
                shot_xpos = 12'(sx);
                shot_ypos = 12'(sy);
            end
            if (noisy && shoot && rel == d + 2) begin
                round_start = 1'b1;
                shot_valid = 1'b1;
                shot_xpos = 12'($urandom_range(0, 4095));
                shot_ypos = 12'($urandom_range(0, 4095));
            end
            tick();
            rel = rel + 1;
            shot_valid = 1'b0;
            round_start = 1'b0;
            if (ball_launch) begin
                launch_cnt = launch_cnt + 1;
                launch_rel = rel;
            end
            if (ball_launch && round_done) clash = 1'b1;
            if (in_flight) begin
                flight_cnt = flight_cnt + 1;
                if (flight_first < 0) flight_first = rel;
            end
            if (round_done) done_rel = rel;
            else if (busy) busy_cnt = busy_cnt + 1;
        end

        vec_count++;
        if (done_rel !== exp_done) begin
            miscompares++;
            $display("FAIL round_done_time: got %0d want %0d", done_rel, exp_done);
        end
        vec_count++;
        if (launch_cnt !== (shoot ? 1 : 0) || launch_rel !== exp_launch_rel) begin
            miscompares++;
            $display("FAIL ball_launch: got count %0d at %0d want count %0d at %0d",
                     launch_cnt, launch_rel, shoot ? 1 : 0, exp_launch_rel);
        end
        vec_count++;
        if (flight_cnt !== (shoot ? FT : 0) || flight_first !== exp_launch_rel) begin
            miscompares++;
            $display("FAIL in_flight: got %0d cycles from %0d want %0d from %0d",
                     flight_cnt, flight_first, shoot ? FT : 0, exp_launch_rel);
        end
        exp_res = exp_q.pop_front();
        vec_count++;
        if ({is_scored, goals, saves, rounds} !== exp_res) begin
            miscompares++;
            $display("FAIL result: got scored=%0b g=%0d s=%0d r=%0d want scored=%0b g=%0d s=%0d r=%0d",
                     is_scored, goals, saves, rounds,
                     exp_res[12], exp_res[11:8], exp_res[7:4], exp_res[3:0]);
        end
        vec_count++;
        if (ball_xpos !== m_bx || ball_ypos !== m_by) begin
            miscompares++;
            $display("FAIL ball_pos: got (%0d,%0d) want (%0d,%0d)", ball_xpos, ball_ypos, m_bx, m_by);
        end
        vec_count++;
        if (busy_cnt !== exp_done || busy !== 1'b0 || clash !== 1'b0) begin
            miscompares++;
            $display("FAIL busy: got %0d busy cycles busy_at_end=%0b clash=%0b want %0d 0 0",
                     busy_cnt, busy, clash, exp_done);
        end
        tick();
        vec_count++;
        if (match_over !== (m_rounds == MR)) begin
            miscompares++;
            $display("FAIL match_over: got %0b want %0b", match_over, m_rounds == MR);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_clear();
        m_bx = '0;
        m_by = '0;
        vec_count++;
        if ({ball_launch, in_flight, is_scored, round_done, match_over, busy} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %06b want 000000",
                     {ball_launch, in_flight, is_scored, round_done, match_over, busy});
        end
        vec_count++;
        if ({goals, saves, rounds, ball_xpos, ball_ypos} !== 36'd0) begin
            miscompares++;
            $display("FAIL reset_values: got g=%0d s=%0d r=%0d ball=(%0d,%0d) want all 0",
                     goals, saves, rounds, ball_xpos, ball_ypos);
        end
    endtask

    // Five directed rounds complete a match, including the hit-window edges.
    task automatic test_full_match();
        bit any_busy;
        run_round(1'b1, 0,      500, 300, 520, 320, 1'b0);
        run_round(1'b1, AT - 1, 500, 300, 600, 300, 1'b0);
        run_round(1'b1, 3,      500, 300, 564, 348, 1'b1);
        run_round(1'b1, 7,      500, 300, 565, 300, 1'b0);
        run_round(1'b1, 1,      500, 300, 436, 300, 1'b1);
        any_busy = 1'b0;
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (busy) any_busy = 1'b1;
            tick();
        end
        vec_count++;
        if (any_busy !== 1'b0 || rounds !== 4'(MR) || match_over !== 1'b1) begin
            miscompares++;
            $display("FAIL start_after_match: got busy=%0b rounds=%0d over=%0b want 0 %0d 1",
                     any_busy, rounds, match_over, MR);
        end
        pulse_clear();
        vec_count++;
        if ({goals, saves, rounds, is_scored, match_over, busy} !== 15'd0) begin
            miscompares++;
            $display("FAIL match_clear: got g=%0d s=%0d r=%0d scored=%0b over=%0b busy=%0b want all 0",
                     goals, saves, rounds, is_scored, match_over, busy);
        end
    endtask

    task automatic test_timeout();
        // Gloves far from the last ball: a judged shot would be a goal.
        run_round(1'b0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        int gx, gy, sx, sy;
        for (int n = 0; n < 14; n++) begin
            if (m_rounds == MR) pulse_clear();
            gx = int'($urandom_range(150, 3945));
            gy = int'($urandom_range(150, 3945));
            sx = gx + int'($urandom_range(0, 260)) - 130;
            sy = gy + int'($urandom_range(0, 200)) - 100;
            run_round($urandom_range(0, 3) != 0, int'($urandom_range(0, AT - 1)),
                      sx, sy, gx, gy, 1'(($urandom_range(0, 1))));
        end
    endtask

    task automatic test_abort_flight();
        bit saw_done;
        if (m_rounds == MR) pulse_clear();
        run_round(1'b1, 2, 700, 400, 700, 400, 1'b0);
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
        for (int rel = 0; rel < 4; rel++) begin
            if (rel == 1) begin
                shot_valid = 1'b1;
                shot_xpos = 12'd900;
                shot_ypos = 12'd100;
            end
            if (rel == 3) match_clear = 1'b1;
            tick();
            shot_valid = 1'b0;
        end
        match_clear = 1'b0;
        model_clear();
        m_bx = 12'd900;
        m_by = 12'd100;
        vec_count++;
        if ({busy, in_flight, ball_launch, goals, saves, rounds} !== 15'd0) begin
            miscompares++;
            $display("FAIL clear_in_flight: got busy=%0b fl=%0b l=%0b g=%0d s=%0d r=%0d want all 0",
                     busy, in_flight, ball_launch, goals, saves, rounds);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (round_done || busy) saw_done = 1'b1;
            tick();
        end
        vec_count++;
        if (saw_done !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_no_done: got activity=%0b want 0", saw_done);
        end
    endtask

    task automatic test_clear_collisions();
        // Shot and clear in the same cycle: no launch, back to IDLE.
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
        shot_valid = 1'b1;
        match_clear = 1'b1;
        shot_xpos = 12'd50;
        shot_ypos = 12'd60;
        tick();
        shot_valid = 1'b0;
        match_clear = 1'b0;
        vec_count++;
        if ({ball_launch, busy, in_flight} !== 3'b0) begin
            miscompares++;
            $display("FAIL clear_vs_shot: got launch=%0b busy=%0b fl=%0b want 0 0 0",
                     ball_launch, busy, in_flight);
        end
        // Clear on the last SHOW cycle: round_done and the rounds bump vanish.
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
        for (int rel = 0; rel < 1 + FT + 1 + ST; rel++) begin
            shot_valid = (rel == 0);
            match_clear = (rel == FT + 1 + ST);
            tick();
            shot_valid = 1'b0;
        end
        match_clear = 1'b0;
        model_clear();
        vec_count++;
        if ({round_done, rounds, busy, goals, saves} !== 14'd0) begin
            miscompares++;
            $display("FAIL clear_vs_done: got done=%0b r=%0d busy=%0b g=%0d s=%0d want all 0",
                     round_done, rounds, busy, goals, saves);
        end
    endtask

    task automatic test_rst_show();
        gloves_xpos = 12'd0;
        gloves_ypos = 12'd0;
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
        for (int rel = 0; rel < 1 + FT + 1 + 1; rel++) begin
            shot_valid = (rel == 0);
            shot_xpos = 12'd2000;
            shot_ypos = 12'd1000;
            tick();
            shot_valid = 1'b0;
        end
        vec_count++;
        if (goals !== 4'd1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL show_entry: got goals=%0d busy=%0b want 1 1", goals, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        m_bx = '0;
        m_by = '0;
        vec_count++;
        if ({ball_launch, in_flight, is_scored, round_done, match_over, busy,
             goals, saves, rounds, ball_xpos, ball_ypos} !== 42'd0) begin
            miscompares++;
            $display("FAIL rst_in_show: got busy=%0b scored=%0b g=%0d s=%0d r=%0d ball=(%0d,%0d) want all 0",
                     busy, is_scored, goals, saves, rounds, ball_xpos, ball_ypos);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_full_match();
        test_timeout();
        test_random();
        test_abort_flight();
        test_clear_collisions();
        test_rst_show();
        run_round(1'b1, 5, 1000, 1000, 1064, 952, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
